// File: rtl/mem_stage_sram.sv
// MEM stage front-end for a 16-bit asynchronous SRAM: each 32-bit access is split into a
// LO then HI half-word phase. Optional address checking is enabled by MEM_ADDR_CHECK_EN.
module mem_stage_sram #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic        ready,
  output logic [31:0] rdata,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N,
  output logic        addr_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [16:0] word_idx;
  logic [31:0] data;
  logic        is_store;

  logic        req;
  logic        in_phase;
  logic        last;
  logic [31:0] offset;
  logic        bad_addr;
  logic        unused_offset_bits;

  assign req      = MEM_R_EN | MEM_W_EN;
  assign in_phase = (state == LO) || (state == HI);
  assign last     = (cnt == CNT_LAST);
  assign offset   = ALU_Res - BASE_ADDR;

`ifdef MEM_ADDR_CHECK_EN
  logic addr_err_q;

  assign bad_addr           = (ALU_Res < BASE_ADDR) || (offset >= 32'h0008_0000) || (ALU_Res[1:0] != 2'b00);
  assign unused_offset_bits = ^offset[1:0];

  // Flag is raised only for the single DONE cycle that follows a rejected request.
  always_ff @(posedge CLK) begin
    if (!RST) addr_err_q <= 1'b0;
    else      addr_err_q <= (state == IDLE) && req && bad_addr;
  end

  assign addr_err = addr_err_q;
`else
  assign bad_addr           = 1'b0;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign addr_err           = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RST) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (req) state <= bad_addr ? DONE : LO;
        end
        LO: begin
          if (last) begin
            if (!is_store) rdata[15:0] <= SRAM_DQ_in;
            cnt   <= 4'd0;
            state <= HI;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HI: begin
          if (last) begin
            if (!is_store) rdata[31:16] <= SRAM_DQ_in;
            cnt   <= 4'd0;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the latched request copies are only observed in LO/HI, which reset never reaches
  // directly, so they carry no reset and stay plain enabled registers.
  always_ff @(posedge CLK) begin
    if (state == IDLE && req) begin
      word_idx <= offset[18:2];
      data     <= Val_Rm;
      is_store <= MEM_W_EN;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    SRAM_ADDR   = 18'd0;
    SRAM_DQ_out = 16'd0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    if (in_phase) begin
      SRAM_ADDR = {word_idx, state == HI};
      if (is_store) begin
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = 1'b0;
        SRAM_DQ_out = (state == HI) ? data[31:16] : data[15:0];
      end
    end
  end

  // Combinational so a fresh request freezes the pipeline in the same cycle it appears.
  assign ready = (state == DONE) || ((state == IDLE) && !req);

endmodule
